// File: rtl/pcie_rb_sink_pkg.sv
// Shared types for the PCIe ring-buffer sink: flit format, default ring
// address width and the drain FSM state encoding.
package pcie_rb_sink_pkg;

  localparam int PDU_AWIDTH = 10;
  localparam int FLIT_W     = 512;

  typedef struct packed {
    logic [FLIT_W-1:0] data;
  } flit_lite_t;

  typedef enum logic [1:0] {
    RB_IDLE,
    RB_FETCH,
    RB_HOLD
  } rb_state_t;

endpackage

// File: rtl/rb_skid_fifo.sv
// Show-ahead skid FIFO that absorbs ring-memory read returns while the
// consumer stalls; the head entry is visible whenever the FIFO is non-empty.
module rb_skid_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 512
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       pop_valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] slot_mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= bump(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= bump(rd_ptr_reg);
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) slot_mem[wr_ptr_reg] <= push_data;
  end

  assign pop_valid = (count_reg != '0);
  assign pop_data  = pop_valid ? slot_mem[rd_ptr_reg] : '0;
  assign count     = count_reg;

endmodule

// File: rtl/pcie_rb_sink.sv
// Ring-buffer sink: writer fills slots and commits them, drain side streams
// flits out in order. Define PCIE_RB_SINK_STATS_EN to add statistics counters.
module pcie_rb_sink
  import pcie_rb_sink_pkg::*;
#(
  parameter int RB_AWIDTH  = PDU_AWIDTH,
  parameter int AF_MARGIN  = 64,
  parameter int MEM_RD_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  flit_lite_t           pcie_rb_wr_data,
  input  logic [RB_AWIDTH-1:0] pcie_rb_wr_addr,
  input  logic                 pcie_rb_wr_en,
  output logic [RB_AWIDTH-1:0] pcie_rb_wr_base_addr,
  output logic                 pcie_rb_almost_full,
  input  logic                 pcie_rb_update_valid,
  input  logic [RB_AWIDTH-1:0] pcie_rb_update_size,
  output logic [FLIT_W-1:0]    out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 rb_err
`ifdef PCIE_RB_SINK_STATS_EN
  ,
  output logic [31:0]          stat_committed,
  output logic [31:0]          stat_drained,
  output logic [31:0]          stat_err_cnt
`endif
);

  localparam int DEPTH      = 1 << RB_AWIDTH;
  localparam int PW         = RB_AWIDTH + 1;
  localparam int SKID_DEPTH = MEM_RD_LAT + 2;
  localparam int SCW        = $clog2(SKID_DEPTH + 1);
  localparam logic [PW-1:0] RING_SIZE = PW'(DEPTH);

  logic [PW-1:0] tail_reg, tail_next, head_reg, head_next, fetch_reg;
  logic [PW-1:0] occ, free, occ_next, free_next, size_ext, wr_off;
  logic          commit_ok, commit_err, wr_err, pop, rd_en, credit_ok, skid_full;
  logic [SCW-1:0] skid_count;
  logic [31:0]   inflight;
  rb_state_t     state_reg, state_next;

  logic [FLIT_W-1:0]     ring_mem [DEPTH];
  logic [FLIT_W-1:0]     rd_data_reg [MEM_RD_LAT];
  logic [MEM_RD_LAT-1:0] rd_vld_reg;

  assign pop        = out_valid & out_ready;
  assign occ        = tail_reg - head_reg;
  assign free       = RING_SIZE - occ;
  assign size_ext   = {1'b0, pcie_rb_update_size};
  assign commit_ok  = pcie_rb_update_valid && (size_ext != '0) && (size_ext <= free);
  assign commit_err = pcie_rb_update_valid && (size_ext > free);
  assign tail_next  = commit_ok ? tail_reg + size_ext : tail_reg;
  assign head_next  = head_reg + PW'(pop);
  assign occ_next   = tail_next - head_next;
  assign free_next  = RING_SIZE - occ_next;
  // Offset from head within the ring; anything below occupancy is unread data.
  assign wr_off     = {1'b0, pcie_rb_wr_addr - head_reg[RB_AWIDTH-1:0]};
  assign wr_err     = pcie_rb_wr_en && (wr_off < occ);
  assign skid_full  = (skid_count == SCW'(SKID_DEPTH));

  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_RD_LAT; i++) inflight = inflight + 32'(rd_vld_reg[i]);
  end

  // Every outstanding read owns a skid slot, so returns can never overflow.
  assign credit_ok = (inflight + 32'(skid_count)) < 32'(SKID_DEPTH);

  always_comb begin
    state_next = state_reg;
    rd_en      = 1'b0;
    case (state_reg)
      RB_IDLE: begin
        if (occ_next != '0) state_next = RB_FETCH;
      end
      RB_FETCH: begin
        rd_en = (fetch_reg != tail_reg) && credit_ok;
        if (occ_next == '0)  state_next = RB_IDLE;
        else if (skid_full)  state_next = RB_HOLD;
      end
      RB_HOLD: begin
        if (!skid_full) state_next = RB_FETCH;
      end
      default: state_next = RB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tail_reg             <= '0;
      head_reg             <= '0;
      fetch_reg            <= '0;
      state_reg            <= RB_IDLE;
      rd_vld_reg           <= '0;
      pcie_rb_wr_base_addr <= '0;
      pcie_rb_almost_full  <= 1'b0;
      rb_err               <= 1'b0;
    end else begin
      tail_reg             <= tail_next;
      head_reg             <= head_next;
      fetch_reg            <= fetch_reg + PW'(rd_en);
      state_reg            <= state_next;
      for (int i = MEM_RD_LAT-1; i > 0; i--) rd_vld_reg[i] <= rd_vld_reg[i-1];
      rd_vld_reg[0]        <= rd_en;
      pcie_rb_wr_base_addr <= tail_next[RB_AWIDTH-1:0];
      pcie_rb_almost_full  <= 32'(free_next) < 32'(AF_MARGIN);
      rb_err               <= rb_err | commit_err | wr_err;
    end
  end

  // Ring storage with registered read followed by extra latency stages.
  always_ff @(posedge clk) begin
    if (pcie_rb_wr_en) ring_mem[pcie_rb_wr_addr] <= pcie_rb_wr_data;
    if (rd_en) rd_data_reg[0] <= ring_mem[fetch_reg[RB_AWIDTH-1:0]];
    for (int i = MEM_RD_LAT-1; i > 0; i--) rd_data_reg[i] <= rd_data_reg[i-1];
  end

  rb_skid_fifo #(
    .DEPTH (SKID_DEPTH),
    .WIDTH (FLIT_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_vld_reg[MEM_RD_LAT-1]),
    .push_data (rd_data_reg[MEM_RD_LAT-1]),
    .pop       (pop),
    .pop_data  (out_data),
    .pop_valid (out_valid),
    .count     (skid_count)
  );

`ifdef PCIE_RB_SINK_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_committed <= '0;
      stat_drained   <= '0;
      stat_err_cnt   <= '0;
    end else begin
      if (commit_ok) stat_committed <= stat_committed + 32'(size_ext);
      stat_drained <= stat_drained + 32'(pop);
      if ((commit_err || wr_err) && (stat_err_cnt != '1)) stat_err_cnt <= stat_err_cnt + 32'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
